// File: rtl/axi_llc_burst_merger_if.sv
// Write-response fragment stream and merged B channel of the LLC burst merger.
// Signal names are given from the merger's point of view; the merger uses the slave modport.
interface axi_llc_burst_merger_if #(
  parameter int unsigned IdWidth = 6
);
  logic               frag_valid_i;
  logic               frag_ready_o;
  logic [IdWidth-1:0] frag_id_i;
  logic [1:0]         frag_resp_i;
  logic               frag_last_i;
  logic               b_valid_o;
  logic               b_ready_i;
  logic [IdWidth-1:0] b_id_o;
  logic [1:0]         b_resp_o;

  modport slave (
    input  frag_valid_i, frag_id_i, frag_resp_i, frag_last_i, b_ready_i,
    output frag_ready_o, b_valid_o, b_id_o, b_resp_o
  );

  modport master (
    output frag_valid_i, frag_id_i, frag_resp_i, frag_last_i, b_ready_i,
    input  frag_ready_o, b_valid_o, b_id_o, b_resp_o
  );
endinterface

// File: rtl/axi_llc_burst_merger.sv
// Merges per-cache-line write completions back into one AXI B beat per original burst.
// Optional statistics counters are enabled with `define AXI_LLC_BURST_MERGER_STAT_EN.
module axi_llc_burst_merger #(
  parameter int unsigned IdWidth  = 6,
  parameter int unsigned CntWidth = 9
) (
  input  logic                clk_i,
  input  logic                rst_i,
  axi_llc_burst_merger_if.slave bus,
  output logic                id_err_o,
  output logic [CntWidth-1:0] frag_cnt_o,
  output logic [31:0]         burst_cnt_o
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } state_e;

  // Pairwise merge is associative: EXOKAY survives only while every fragment so far was EXOKAY.
  function automatic logic [1:0] merge_resp(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] r;
    if ((a == RESP_DECERR) || (b == RESP_DECERR)) begin
      r = RESP_DECERR;
    end else if ((a == RESP_SLVERR) || (b == RESP_SLVERR)) begin
      r = RESP_SLVERR;
    end else if ((a == RESP_EXOKAY) && (b == RESP_EXOKAY)) begin
      r = RESP_EXOKAY;
    end else begin
      r = RESP_OKAY;
    end
    return r;
  endfunction

  state_e             state_q, state_d;
  logic [IdWidth-1:0] acc_id_q, acc_id_d;
  logic [1:0]         acc_resp_q, acc_resp_d;
  logic               b_valid_q, b_valid_d;
  logic [IdWidth-1:0] b_id_q, b_id_d;
  logic [1:0]         b_resp_q, b_resp_d;
  logic               id_err_q, id_err_d;

  logic frag_ready_s;
  logic frag_hs_s;
  logic b_hs_s;
  logic first_s;
  logic id_mis_s;

  // A fragment is first of its burst unless one is already open; in OUT it can only enter with the B handshake.
  assign frag_ready_s = (state_q != OUT) | bus.b_ready_i;
  assign frag_hs_s    = bus.frag_valid_i & frag_ready_s;
  assign b_hs_s       = b_valid_q & bus.b_ready_i;
  assign first_s      = (state_q != ACCUM);
  assign id_mis_s     = ~first_s & (bus.frag_id_i != acc_id_q);

  // Next-state, accumulator and B output logic.
  always_comb begin
    state_d    = state_q;
    acc_id_d   = acc_id_q;
    acc_resp_d = acc_resp_q;
    b_valid_d  = b_valid_q;
    b_id_d     = b_id_q;
    b_resp_d   = b_resp_q;
    id_err_d   = 1'b0;

    if (b_hs_s) begin
      b_valid_d = 1'b0;
    end else begin
      b_valid_d = b_valid_q;
    end

    if (frag_hs_s) begin
      if (first_s) begin
        acc_id_d   = bus.frag_id_i;
        acc_resp_d = bus.frag_resp_i;
      end else if (id_mis_s) begin
        acc_resp_d = merge_resp(merge_resp(acc_resp_q, bus.frag_resp_i), RESP_SLVERR);
      end else begin
        acc_resp_d = merge_resp(acc_resp_q, bus.frag_resp_i);
      end
      id_err_d = id_mis_s;
      if (bus.frag_last_i) begin
        b_valid_d = 1'b1;
        b_id_d    = acc_id_d;
        b_resp_d  = acc_resp_d;
        state_d   = OUT;
      end else begin
        state_d   = ACCUM;
      end
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        ACCUM:   state_d = ACCUM;
        OUT:     state_d = b_hs_s ? IDLE : OUT;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      acc_id_q   <= '0;
      acc_resp_q <= RESP_OKAY;
      b_valid_q  <= 1'b0;
      b_id_q     <= '0;
      b_resp_q   <= RESP_OKAY;
      id_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_id_q   <= acc_id_d;
      acc_resp_q <= acc_resp_d;
      b_valid_q  <= b_valid_d;
      b_id_q     <= b_id_d;
      b_resp_q   <= b_resp_d;
      id_err_q   <= id_err_d;
    end
  end

`ifdef AXI_LLC_BURST_MERGER_STAT_EN
  logic [CntWidth-1:0] acc_cnt_q, acc_cnt_d;
  logic [CntWidth-1:0] frag_cnt_q;
  logic [31:0]         burst_cnt_q;

  // Fragment count of the open burst, saturating at all-ones.
  always_comb begin
    acc_cnt_d = acc_cnt_q;
    if (frag_hs_s) begin
      if (first_s) begin
        acc_cnt_d = {{(CntWidth-1){1'b0}}, 1'b1};
      end else if (&acc_cnt_q) begin
        acc_cnt_d = acc_cnt_q;
      end else begin
        acc_cnt_d = acc_cnt_q + {{(CntWidth-1){1'b0}}, 1'b1};
      end
    end else begin
      acc_cnt_d = acc_cnt_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_cnt_q   <= '0;
      frag_cnt_q  <= '0;
      burst_cnt_q <= 32'd0;
    end else begin
      acc_cnt_q <= acc_cnt_d;
      if (frag_hs_s && bus.frag_last_i) begin
        frag_cnt_q <= acc_cnt_d;
      end
      if (b_hs_s) begin
        burst_cnt_q <= burst_cnt_q + 32'd1;
      end
    end
  end

  assign frag_cnt_o  = frag_cnt_q;
  assign burst_cnt_o = burst_cnt_q;
`else
  assign frag_cnt_o  = '0;
  assign burst_cnt_o = 32'd0;
`endif

  assign bus.frag_ready_o = frag_ready_s;
  assign bus.b_valid_o    = b_valid_q;
  assign bus.b_id_o       = b_id_q;
  assign bus.b_resp_o     = b_resp_q;
  assign id_err_o         = id_err_q;

endmodule

// File: tb/tb_axi_llc_burst_merger.sv
// Directed self-checking bench for axi_llc_burst_merger (either statistics build).
module tb_axi_llc_burst_merger;

  localparam int unsigned IdWidth  = 6;
  localparam int unsigned CntWidth = 9;

  logic                clk;
  logic                rst;
  logic                id_err;
  logic [CntWidth-1:0] frag_cnt;
  logic [31:0]         burst_cnt;

  int vectors;
  int miscompares;

  axi_llc_burst_merger_if #(.IdWidth(IdWidth)) bus ();

  axi_llc_burst_merger #(.IdWidth(IdWidth), .CntWidth(CntWidth)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bus),
    .id_err_o    (id_err),
    .frag_cnt_o  (frag_cnt),
    .burst_cnt_o (burst_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [5:0] id, input logic [1:0] resp, input logic last);
    bus.frag_valid_i = 1'b1;
    bus.frag_id_i    = id;
    bus.frag_resp_i  = resp;
    bus.frag_last_i  = last;
    tick();
    bus.frag_valid_i = 1'b0;
  endtask

  function automatic logic [31:0] stat(input logic [31:0] v);
`ifdef AXI_LLC_BURST_MERGER_STAT_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  initial begin
    vectors          = 0;
    miscompares      = 0;
    rst              = 1'b1;
    bus.frag_valid_i = 1'b0;
    bus.frag_id_i    = 6'd0;
    bus.frag_resp_i  = 2'b00;
    bus.frag_last_i  = 1'b0;
    bus.b_ready_i    = 1'b1;
    tick();
    tick();
    check("rst_b_valid", {31'd0, bus.b_valid_o}, 32'd0);
    check("rst_b_id", {26'd0, bus.b_id_o}, 32'd0);
    check("rst_b_resp", {30'd0, bus.b_resp_o}, 32'd0);
    check("rst_id_err", {31'd0, id_err}, 32'd0);
    check("rst_frag_cnt", {23'd0, frag_cnt}, 32'd0);
    check("rst_burst_cnt", burst_cnt, 32'd0);
    rst = 1'b0;
    tick();

    // Single fragment burst
    send(6'd5, 2'b00, 1'b1);
    check("single_valid", {31'd0, bus.b_valid_o}, 32'd1);
    check("single_id", {26'd0, bus.b_id_o}, 32'd5);
    check("single_resp", {30'd0, bus.b_resp_o}, 32'd0);
    check("single_cnt", {23'd0, frag_cnt}, stat(32'd1));
    tick();
    check("single_drain", {31'd0, bus.b_valid_o}, 32'd0);
    check("single_bcnt", burst_cnt, stat(32'd1));

    // Three fragments OKAY/SLVERR/OKAY
    send(6'd3, 2'b00, 1'b0);
    check("three_no_b", {31'd0, bus.b_valid_o}, 32'd0);
    send(6'd3, 2'b10, 1'b0);
    send(6'd3, 2'b00, 1'b1);
    check("three_valid", {31'd0, bus.b_valid_o}, 32'd1);
    check("three_id", {26'd0, bus.b_id_o}, 32'd3);
    check("three_resp", {30'd0, bus.b_resp_o}, 32'd2);
    check("three_cnt", {23'd0, frag_cnt}, stat(32'd3));
    tick();

    // Resp merge corners
    send(6'd1, 2'b01, 1'b0);
    send(6'd1, 2'b01, 1'b1);
    check("exok_exok", {30'd0, bus.b_resp_o}, 32'd1);
    tick();
    send(6'd1, 2'b01, 1'b0);
    send(6'd1, 2'b00, 1'b1);
    check("exok_okay", {30'd0, bus.b_resp_o}, 32'd0);
    tick();
    send(6'd1, 2'b10, 1'b0);
    send(6'd1, 2'b11, 1'b1);
    check("slv_dec", {30'd0, bus.b_resp_o}, 32'd3);
    tick();

    // Back-to-back single bursts
    send(6'd10, 2'b00, 1'b1);
    send(6'd11, 2'b01, 1'b1);
    check("b2b_valid", {31'd0, bus.b_valid_o}, 32'd1);
    check("b2b_id", {26'd0, bus.b_id_o}, 32'd11);
    check("b2b_resp", {30'd0, bus.b_resp_o}, 32'd1);
    tick();
    check("b2b_drain", {31'd0, bus.b_valid_o}, 32'd0);

    // Backpressure with next fragment pending
    bus.b_ready_i = 1'b0;
    send(6'd6, 2'b10, 1'b1);
    bus.frag_valid_i = 1'b1;
    bus.frag_id_i    = 6'd9;
    bus.frag_resp_i  = 2'b00;
    bus.frag_last_i  = 1'b1;
    #1;
    check("bp_ready0", {31'd0, bus.frag_ready_o}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_valid", {31'd0, bus.b_valid_o}, 32'd1);
      check("bp_id", {26'd0, bus.b_id_o}, 32'd6);
      check("bp_resp", {30'd0, bus.b_resp_o}, 32'd2);
      check("bp_ready", {31'd0, bus.frag_ready_o}, 32'd0);
    end
    bus.b_ready_i = 1'b1;
    #1;
    check("bp_ready1", {31'd0, bus.frag_ready_o}, 32'd1);
    tick();
    bus.frag_valid_i = 1'b0;
    check("bp_next_valid", {31'd0, bus.b_valid_o}, 32'd1);
    check("bp_next_id", {26'd0, bus.b_id_o}, 32'd9);
    check("bp_next_resp", {30'd0, bus.b_resp_o}, 32'd0);
    tick();
    check("bp_drain", {31'd0, bus.b_valid_o}, 32'd0);

    // Id mismatch
    send(6'd2, 2'b00, 1'b0);
    check("iderr_quiet", {31'd0, id_err}, 32'd0);
    send(6'd4, 2'b00, 1'b1);
    check("iderr_pulse", {31'd0, id_err}, 32'd1);
    check("iderr_id", {26'd0, bus.b_id_o}, 32'd2);
    check("iderr_resp", {30'd0, bus.b_resp_o}, 32'd2);
    tick();
    check("iderr_clear", {31'd0, id_err}, 32'd0);

    // Reset mid-burst
    send(6'd1, 2'b00, 1'b0);
    send(6'd1, 2'b00, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", {31'd0, bus.b_valid_o}, 32'd0);
    check("mid_rst_bcnt", burst_cnt, 32'd0);
    tick();
    check("mid_rst_still", {31'd0, bus.b_valid_o}, 32'd0);
    send(6'd7, 2'b00, 1'b1);
    check("post_rst_valid", {31'd0, bus.b_valid_o}, 32'd1);
    check("post_rst_id", {26'd0, bus.b_id_o}, 32'd7);
    check("post_rst_cnt", {23'd0, frag_cnt}, stat(32'd1));
    tick();
    check("post_rst_bcnt", burst_cnt, stat(32'd1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
